// File: rtl/inert_chnl_rdr_pkg.sv
// -----------------------------------------------------------------------------
// inert_pkg
// Shared types and helpers for the inertial-sensor channel reader.
//   state_t   : sequencer states
//   RD_BIT    : SPI command MSB marking a register read
//   IDX_W     : width of the shared init/read index (covers up to 16 steps)
//   mk_rd_cmd : builds a 16-bit read command from a 7-bit register address
// -----------------------------------------------------------------------------
package inert_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_ISS,
    INIT_BSY,
    WAIT,
    RD_ISS,
    RD_BSY
  } state_t;

  localparam logic        RD_BIT = 1'b1;
  localparam int unsigned IDX_W  = 4;

  function automatic logic [15:0] mk_rd_cmd(input logic [6:0] addr7);
    return {RD_BIT, addr7, 8'h00};
  endfunction

endpackage

// File: rtl/inert_chnl_rdr_sync.sv
// -----------------------------------------------------------------------------
// inert_sync
// Two-flop synchronizer for an asynchronous level, plus a rising-edge pulse
// derived from the synchronized level.
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset
//   i_async : asynchronous input
//   o_sync  : synchronized level (2-clk latency)
//   o_rise  : 1-clk pulse on a 0->1 transition of o_sync
// -----------------------------------------------------------------------------
module inert_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/inert_chnl_rdr.sv
// -----------------------------------------------------------------------------
// inert_chnl_rdr
// Inertial-sensor read sequencer. After a power-up delay it writes NUM_INIT
// init words to the sensor, then on every trigger from INT reads NUM_CH
// 16-bit channels (low byte then high byte) through an external SPI master.
//   clk, rst_n : clock, synchronous active-low reset
//   INT        : async sensor data-ready
//   init_cmd   : init words, word i at [16i+15:16i]
//   ch_addr    : low-byte register address per channel, 7 bits each
//   wrt, cmd   : SPI transaction start pulse and command (held until done)
//   done       : SPI transaction complete, rd_data valid with it
//   rdy        : init sequence complete (held)
//   vld        : ch_data updated this cycle
//   ch_data    : channel c = {hi,lo} at [16c+15:16c]
//   ovr        : INT rising edge seen during an active read burst
//   err        : sticky SPI timeout flag
// -----------------------------------------------------------------------------
module inert_chnl_rdr
  import inert_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned NUM_INIT   = 4,
  parameter int unsigned PWRUP_BITS = 16,
  parameter int unsigned TMO_BITS   = 10,
  parameter bit          EDGE_TRIG  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    INT,
  input  logic [16*NUM_INIT-1:0]  init_cmd,
  input  logic [7*NUM_CH-1:0]     ch_addr,
  output logic                    wrt,
  output logic [15:0]             cmd,
  input  logic                    done,
  input  logic [7:0]              rd_data,
  output logic                    rdy,
  output logic                    vld,
  output logic [16*NUM_CH-1:0]    ch_data,
  output logic                    ovr,
  output logic                    err
);

  state_t                  r_state, w_nxt_state;
  logic [IDX_W-1:0]        r_idx;
  logic [PWRUP_BITS-1:0]   r_pwr_cnt;
  logic [TMO_BITS-1:0]     r_tmo_cnt;
  // The final byte of a burst goes straight to ch_data, so the shadow only
  // holds the bytes before it.
  logic [16*NUM_CH-9:0]    r_shadow;
  logic [16*NUM_CH-1:0]    r_ch_data;
  logic                    r_rdy, r_vld, r_ovr, r_err;

  logic                    w_sync, w_rise, w_trig;
  logic                    w_pwr_done, w_tmo_exp, w_last_init, w_last_rd;
  logic [6:0]              w_rd_addr;
  logic [15:0]             w_init_word;

  inert_sync u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_async (INT),
    .o_sync  (w_sync),
    .o_rise  (w_rise)
  );

  assign w_trig      = EDGE_TRIG ? w_rise : w_sync;
  assign w_pwr_done  = &r_pwr_cnt;
  assign w_tmo_exp   = &r_tmo_cnt;
  assign w_last_init = (r_idx == IDX_W'(NUM_INIT - 1));
  assign w_last_rd   = (r_idx == IDX_W'(2*NUM_CH - 1));
  assign w_init_word = init_cmd[32'(r_idx)*16 +: 16];
  // idx>>1 selects the channel, idx[0] selects low/high byte register.
  assign w_rd_addr   = ch_addr[32'(r_idx[IDX_W-1:1])*7 +: 7] + {6'b0, r_idx[0]};

  always_comb begin
    w_nxt_state = r_state;
    wrt         = 1'b0;
    cmd         = '0;
    case (r_state)
      PWRUP:    if (w_pwr_done) w_nxt_state = INIT_ISS;
      INIT_ISS: begin
        wrt         = 1'b1;
        cmd         = w_init_word;
        w_nxt_state = INIT_BSY;
      end
      INIT_BSY: begin
        cmd = w_init_word;
        if (done)           w_nxt_state = w_last_init ? WAIT : INIT_ISS;
        else if (w_tmo_exp) w_nxt_state = PWRUP;
      end
      WAIT:     if (w_trig) w_nxt_state = RD_ISS;
      RD_ISS: begin
        wrt         = 1'b1;
        cmd         = mk_rd_cmd(w_rd_addr);
        w_nxt_state = RD_BSY;
      end
      RD_BSY: begin
        cmd = mk_rd_cmd(w_rd_addr);
        if (done)           w_nxt_state = w_last_rd ? WAIT : RD_ISS;
        else if (w_tmo_exp) w_nxt_state = WAIT;
      end
      default:  w_nxt_state = PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= PWRUP;
      r_idx     <= '0;
      r_pwr_cnt <= '0;
      r_tmo_cnt <= '0;
      r_shadow  <= '0;
      r_ch_data <= '0;
      r_rdy     <= 1'b0;
      r_vld     <= 1'b0;
      r_ovr     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_vld     <= 1'b0;
      r_ovr     <= w_rise && (r_state == RD_ISS || r_state == RD_BSY);
      // Cleared outside PWRUP so a timed-out init gets the full delay again.
      r_pwr_cnt <= (r_state == PWRUP) ? r_pwr_cnt + PWRUP_BITS'(1) : '0;
      if (wrt)
        r_tmo_cnt <= '0;
      else if (r_state == INIT_BSY || r_state == RD_BSY)
        r_tmo_cnt <= r_tmo_cnt + TMO_BITS'(1);

      case (r_state)
        PWRUP: if (w_pwr_done) r_idx <= '0;
        INIT_BSY: begin
          if (done) begin
            if (w_last_init) r_rdy <= 1'b1;
            else             r_idx <= r_idx + IDX_W'(1);
          end else if (w_tmo_exp) begin
            r_err <= 1'b1;
          end
        end
        WAIT: if (w_trig) r_idx <= '0;
        RD_BSY: begin
          if (done) begin
            if (w_last_rd) begin
              r_ch_data <= {rd_data, r_shadow};
              r_vld     <= 1'b1;
            end else begin
              r_shadow[32'(r_idx)*8 +: 8] <= rd_data;
              r_idx                       <= r_idx + IDX_W'(1);
            end
          end else if (w_tmo_exp) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rdy     = r_rdy;
  assign vld     = r_vld;
  assign ovr     = r_ovr;
  assign err     = r_err;
  assign ch_data = r_ch_data;

endmodule
